// File: rtl/rand_pkg.sv
// Shared defaults for the random-word packing path.
package rand_pkg;

  localparam int DEF_WORD_WIDTH = 6;
  localparam int DEF_DROP_WIDTH = 8;
  localparam int CNT_W          = $clog2(DEF_WORD_WIDTH);

  // Bit-counter width for an arbitrary word width.
  function automatic int cnt_width(input int word_width);
    return (word_width <= 2) ? 1 : $clog2(word_width);
  endfunction

endpackage

// File: rtl/rand_word_packer.sv
// Packs qualified serial random bits into WORD_WIDTH words behind a one-slot
// valid/ready output; words completed while the slot is occupied are counted and lost.
module rand_word_packer
  import rand_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int DROP_WIDTH = DEF_DROP_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_bit,
  input  logic                  i_bit_en,
  input  logic                  i_flush,
  output logic [WORD_WIDTH-1:0] o_word,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DROP_WIDTH-1:0] o_drop_cnt
);

  localparam int            CW   = cnt_width(WORD_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WORD_WIDTH - 1);

  logic [WORD_WIDTH-1:0] sr_reg;
  logic [CW-1:0]         cnt_reg;
  logic [WORD_WIDTH-1:0] word_reg;
  logic                  valid_reg;
  logic [DROP_WIDTH-1:0] drop_reg;

  logic [WORD_WIDTH-1:0] shifted;
  logic                  complete;
  logic                  handshake;
  logic                  drop_sat;

  // The completed word includes the bit arriving this cycle.
  assign shifted   = {sr_reg[WORD_WIDTH-2:0], i_bit};
  assign complete  = i_bit_en & ~i_flush & (cnt_reg == LAST);
  assign handshake = valid_reg & i_ready;
  assign drop_sat  = &drop_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sr_reg    <= '0;
      cnt_reg   <= '0;
      word_reg  <= '0;
      valid_reg <= 1'b0;
      drop_reg  <= '0;
    end else begin
      if (i_flush) begin
        sr_reg   <= '0;
        cnt_reg  <= '0;
        drop_reg <= '0;
      end else if (i_bit_en) begin
        sr_reg  <= shifted;
        cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + CW'(1);
        if (complete && valid_reg && !i_ready && !drop_sat)
          drop_reg <= drop_reg + DROP_WIDTH'(1);
      end

      // A handshake coinciding with completion reloads the slot without a gap.
      if (complete && (!valid_reg || i_ready)) begin
        word_reg  <= shifted;
        valid_reg <= 1'b1;
      end else if (handshake) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign o_word     = word_reg;
  assign o_valid    = valid_reg;
  assign o_drop_cnt = drop_reg;

endmodule

// File: tb/tb_rand_word_packer.sv
// Directed bench for rand_word_packer: vector table plus multi-cycle sequences.
module tb_rand_word_packer;

  logic       clk;
  logic       rst_n;
  logic       bit_in;
  logic       bit_en;
  logic       flush;
  logic       ready;
  logic [5:0] word_a;
  logic       valid_a;
  logic [7:0] drop_a;
  logic [5:0] word_s;
  logic       valid_s;
  logic [1:0] drop_s;

  int total = 0;
  int bad   = 0;

  rand_word_packer #(.WORD_WIDTH(6), .DROP_WIDTH(8)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_bit(bit_in), .i_bit_en(bit_en),
    .i_flush(flush), .o_word(word_a), .o_valid(valid_a), .i_ready(ready),
    .o_drop_cnt(drop_a)
  );

  rand_word_packer #(.WORD_WIDTH(6), .DROP_WIDTH(2)) u_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_bit(bit_in), .i_bit_en(bit_en),
    .i_flush(flush), .o_word(word_s), .o_valid(valid_s), .i_ready(ready),
    .o_drop_cnt(drop_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       b;
    logic       en;
    logic       rdy;
    logic       fl;
    logic [5:0] ew;
    logic       ev;
    logic [7:0] ed;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic b, input logic en, input logic rdy, input logic fl);
    bit_in = b;
    bit_en = en;
    ready  = rdy;
    flush  = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic b, input logic en, input logic rdy, input logic fl,
                     input logic [5:0] ew, input logic ev, input logic [7:0] ed);
    vec_t v;
    v.b = b; v.en = en; v.rdy = rdy; v.fl = fl; v.ew = ew; v.ev = ev; v.ed = ed;
    vecs.push_back(v);
  endtask

  // Six enabled bits MSB-first; expectations for the first five cycles and the last.
  task automatic add_word(input logic [5:0] w, input logic rdy_mid, input logic rdy_last,
                          input logic [5:0] ew0, input logic ev0, input logic [7:0] ed0,
                          input logic [5:0] ew1, input logic ev1, input logic [7:0] ed1);
    for (int i = 0; i < 5; i++) add(w[5-i], 1'b1, rdy_mid, 1'b0, ew0, ev0, ed0);
    add(w[0], 1'b1, rdy_last, 1'b0, ew1, ev1, ed1);
  endtask

  task automatic feed_word(input logic [5:0] w, input logic rdy);
    for (int i = 0; i < 6; i++) step(w[5-i], 1'b1, rdy, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [5:0] msr;
    int         mcnt;
    int         pulses;
    logic       b;
    logic       en;
    logic       exp_v;
    logic [5:0] exp_w;

    bit_in = 1'b0; bit_en = 1'b0; flush = 1'b0; ready = 1'b0;
    rst_n  = 1'b0;
    #2;
    chk("rst_word", word_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_drop", drop_a, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic packing, back-to-back handshake, drops while full.
    add_word(6'b101101, 1, 1, 6'h00, 0, 0, 6'h2D, 1, 0);
    add(0, 0, 1, 0, 6'h2D, 0, 0);
    add(0, 0, 0, 0, 6'h2D, 0, 0);
    add_word(6'b110011, 0, 0, 6'h2D, 0, 0, 6'h33, 1, 0);
    add_word(6'b010101, 0, 1, 6'h33, 1, 0, 6'h15, 1, 0);
    add(0, 0, 1, 0, 6'h15, 0, 0);
    add_word(6'b111000, 0, 0, 6'h15, 0, 0, 6'h38, 1, 0);
    add_word(6'b000111, 0, 0, 6'h38, 1, 0, 6'h38, 1, 1);
    add_word(6'b101010, 0, 0, 6'h38, 1, 1, 6'h38, 1, 2);
    add(0, 0, 1, 0, 6'h38, 0, 2);
    add_word(6'b011110, 0, 0, 6'h38, 0, 2, 6'h1E, 1, 2);
    add(0, 0, 1, 0, 6'h1E, 0, 2);

    foreach (vecs[i]) begin
      step(vecs[i].b, vecs[i].en, vecs[i].rdy, vecs[i].fl);
      $display("vec %0d: b=%0b en=%0b rdy=%0b fl=%0b -> word=%h valid=%0b drop=%0d",
               i, vecs[i].b, vecs[i].en, vecs[i].rdy, vecs[i].fl, word_a, valid_a, drop_a);
      chk($sformatf("vec%0d_word", i), word_a, vecs[i].ew);
      chk($sformatf("vec%0d_valid", i), valid_a, vecs[i].ev);
      chk($sformatf("vec%0d_drop", i), drop_a, vecs[i].ed);
      chk($sformatf("vec%0d_sat_drop", i), drop_s, vecs[i].ed[1:0]);
    end

    // Asynchronous reset mid-word, then a clean word.
    step(1, 1, 1, 0);
    step(1, 1, 1, 0);
    step(1, 1, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_word", word_a, 0);
    chk("midrst_valid", valid_a, 0);
    chk("midrst_drop", drop_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(i == 0 || i == 3 || i == 4, 1, 1, 0);
    chk("postrst_valid_early", valid_a, 0);
    step(0, 1, 1, 0);
    $display("post-reset word=%h valid=%0b", word_a, valid_a);
    chk("postrst_word", word_a, 6'h26);
    chk("postrst_valid", valid_a, 1);

    // Random streams against a packing model, ready held high.
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      msr = '0; mcnt = 0; pulses = 0;
      for (int c = 0; c < 120; c++) begin
        b  = 1'($urandom_range(0, 1));
        en = (pass == 0) ? 1'b1 : ((c % 2) == 0);
        exp_v = 1'b0;
        exp_w = {msr[4:0], b};
        if (en) begin
          exp_v = (mcnt == 5);
          msr   = exp_w;
          mcnt  = (mcnt == 5) ? 0 : mcnt + 1;
        end
        step(b, en, 1, 0);
        if (exp_v) pulses++;
        if (valid_a !== exp_v) chk($sformatf("stream%0d_valid_c%0d", pass, c), valid_a, exp_v);
        if (exp_v) begin
          $display("stream%0d word=%h", pass, word_a);
          chk($sformatf("stream%0d_word_c%0d", pass, c), word_a, exp_w);
        end
      end
      chk($sformatf("stream%0d_pulses", pass), pulses, (pass == 0) ? 20 : 10);
      chk($sformatf("stream%0d_drop", pass), drop_a, 0);
    end

    // Saturating drop counter, then flush on the completing bit.
    do_reset();
    feed_word(6'b100001, 0);
    chk("sat_first_word", word_s, 6'h21);
    for (int w = 0; w < 5; w++) feed_word(6'b111111, 0);
    $display("after 6 words: sat_drop=%0d drop=%0d", drop_s, drop_a);
    chk("sat_drop", drop_s, 3);
    chk("wide_drop", drop_a, 5);
    for (int i = 0; i < 5; i++) step(i % 2, 1, 0, 0);
    step(1, 1, 0, 1);
    chk("flush_sat_drop", drop_s, 0);
    chk("flush_wide_drop", drop_a, 0);
    chk("flush_valid", valid_s, 1);
    chk("flush_word", word_s, 6'h21);
    step(0, 0, 1, 0);
    chk("flush_handshake_valid", valid_s, 0);
    for (int i = 0; i < 5; i++) begin
      step(i == 2 || i == 3, 1, 0, 0);
      chk($sformatf("fresh_bit%0d_valid", i), valid_s, 0);
    end
    step(0, 1, 0, 0);
    $display("fresh word=%h valid=%0b drop=%0d", word_s, valid_s, drop_s);
    chk("fresh_valid", valid_s, 1);
    chk("fresh_word", word_s, 6'h0C);
    chk("fresh_drop", drop_s, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
